// File: rtl/control_unit_v2.sv
// control_unit_v2 -- hardwired multi-cycle control sequencer.
//
// Fetches an instruction in three steps (T0..T2), then executes it in
// EXEC steps 3..7. Each step takes one clock unless it is a memory step
// waiting on mem_ready. Sticky HALT and FAULT states are left only through clr.
//
// Ports:
//   clk         rising-edge clock
//   clr         asynchronous active-low reset
//   run_en      permits starting a new instruction
//   IR          instruction register; opcode = IR[IR_W-1 -: OPC_W]
//   mem_ready   memory finishes the current access this cycle
//   con_ff      branch condition result
//   reg_ctl     {Gra,Grb,Grc,Rin,Rout,BAout,y_in}
//   ld_ctl      {MARin,mdr_in,ir_in,pc_in,z_in,hi_in,lo_in,CON_FF_in}
//   bus_ctl     {pc_out,mdr_out,zlow_out,zhigh_out,c_out,hi_out,lo_out}
//   alu_control ALU operation code
//   mem_ctl     {memRead,memWrite}
//   busy        fetching or executing
//   halted      halt instruction executed
//   instr_done  final step of a completing instruction
//   fault       01 illegal opcode, 10 memory timeout
module control_unit_v2 #(
  parameter int IR_W        = 32,
  parameter int OPC_W       = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run_en,
  input  logic [IR_W-1:0] IR,
  input  logic            mem_ready,
  input  logic            con_ff,
  output logic [6:0]      reg_ctl,
  output logic [7:0]      ld_ctl,
  output logic [6:0]      bus_ctl,
  output logic [4:0]      alu_control,
  output logic [1:0]      mem_ctl,
  output logic            busy,
  output logic            halted,
  output logic            instr_done,
  output logic [1:0]      fault
);

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_EXEC, S_HALT, S_FAULT} state_t;

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(MEM_TIMEOUT - 1);

  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_NEG  = OPC_W'(17);
  localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(18);
  localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(19);
  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(26);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(27);

  state_t           state, next_state;
  logic [2:0]       step, next_step;
  logic [WCW-1:0]   wait_cnt;
  logic [1:0]       fault_q, next_fault;

  logic [OPC_W-1:0] opcode;
  logic [4:0]       opc_alu;
  logic             unused_ir;

  logic gra, grb, grc, rin, rout, ba_out, y_in;
  logic mar_in, mdr_in, ir_in, pc_in, z_in, hi_in, lo_in, con_ff_in;
  logic pc_out, mdr_out, zlow_out, zhigh_out, c_out, hi_out, lo_out;
  logic [4:0] alu;
  logic mem_read, mem_write;
  logic mem_step, last_step, go_halt, go_fault;

  assign opcode    = IR[IR_W-1 -: OPC_W];
  assign opc_alu   = 5'(opcode);
  assign unused_ir = ^IR[IR_W-OPC_W-1:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_IDLE;
      step     <= 3'd3;
      wait_cnt <= '0;
      fault_q  <= 2'b00;
    end else begin
      state   <= next_state;
      step    <= next_step;
      fault_q <= next_fault;
      // Counts consecutive low cycles of the current memory step only.
      if (mem_step && !mem_ready)
        wait_cnt <= wait_cnt + WCW'(1);
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    next_state = state;
    next_step  = step;
    next_fault = fault_q;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0; ba_out = 1'b0; y_in = 1'b0;
    mar_in = 1'b0; mdr_in = 1'b0; ir_in = 1'b0; pc_in = 1'b0; z_in = 1'b0;
    hi_in = 1'b0; lo_in = 1'b0; con_ff_in = 1'b0;
    pc_out = 1'b0; mdr_out = 1'b0; zlow_out = 1'b0; zhigh_out = 1'b0;
    c_out = 1'b0; hi_out = 1'b0; lo_out = 1'b0;
    alu = 5'd0;
    mem_read = 1'b0; mem_write = 1'b0;
    instr_done = 1'b0;
    mem_step = 1'b0; last_step = 1'b0; go_halt = 1'b0; go_fault = 1'b0;

    case (state)
      S_IDLE: if (run_en) next_state = S_T0;
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; z_in = 1'b1; alu = 5'd19;
        next_state = S_T1;
      end
      S_T1: begin
        zlow_out = 1'b1; pc_in = 1'b1; mem_read = 1'b1; mdr_in = 1'b1;
        mem_step = 1'b1;
        next_state = S_T2;
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        next_state = S_EXEC;
        next_step  = 3'd3;
      end
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (step)
              3'd3: begin grb = 1'b1; rout = 1'b1; y_in = 1'b1; end
              3'd4: begin
                z_in = 1'b1;
                if (opcode == OP_ADDI) begin c_out = 1'b1; alu = 5'd3; end
                else if (opcode == OP_ANDI) begin c_out = 1'b1; alu = 5'd5; end
                else if (opcode == OP_ORI) begin c_out = 1'b1; alu = 5'd6; end
                else begin grc = 1'b1; rout = 1'b1; alu = opc_alu; end
              end
              3'd5: begin zlow_out = 1'b1; gra = 1'b1; rin = 1'b1; last_step = 1'b1; end
              default: ;
            endcase
          end
          OP_LD, OP_LDI, OP_ST: begin
            case (step)
              3'd3: begin grb = 1'b1; ba_out = 1'b1; rout = 1'b1; y_in = 1'b1; end
              3'd4: begin c_out = 1'b1; z_in = 1'b1; alu = 5'd3; end
              3'd5: begin
                zlow_out = 1'b1;
                if (opcode == OP_LDI) begin gra = 1'b1; rin = 1'b1; last_step = 1'b1; end
                else mar_in = 1'b1;
              end
              3'd6: begin
                mdr_in = 1'b1;
                if (opcode == OP_ST) begin gra = 1'b1; rout = 1'b1; end
                else begin mem_read = 1'b1; mem_step = 1'b1; end
              end
              3'd7: begin
                last_step = 1'b1;
                if (opcode == OP_ST) begin mem_write = 1'b1; mem_step = 1'b1; end
                else begin mdr_out = 1'b1; gra = 1'b1; rin = 1'b1; end
              end
              default: ;
            endcase
          end
          OP_DIV, OP_MUL: begin
            case (step)
              3'd3: begin gra = 1'b1; rout = 1'b1; y_in = 1'b1; end
              3'd4: begin grb = 1'b1; rout = 1'b1; z_in = 1'b1; alu = opc_alu; end
              3'd5: begin zlow_out = 1'b1; lo_in = 1'b1; end
              3'd6: begin zhigh_out = 1'b1; hi_in = 1'b1; last_step = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (step)
              3'd3: begin grb = 1'b1; rout = 1'b1; z_in = 1'b1; alu = opc_alu; end
              3'd4: begin zlow_out = 1'b1; gra = 1'b1; rin = 1'b1; last_step = 1'b1; end
              default: ;
            endcase
          end
          OP_BR: begin
            case (step)
              3'd3: begin gra = 1'b1; rout = 1'b1; con_ff_in = 1'b1; end
              3'd4: begin pc_out = 1'b1; y_in = 1'b1; end
              3'd5: begin c_out = 1'b1; z_in = 1'b1; alu = 5'd3; end
              3'd6: begin zlow_out = 1'b1; pc_in = con_ff; last_step = 1'b1; end
              default: ;
            endcase
          end
          OP_NOP:  last_step = 1'b1;
          OP_HALT: go_halt = 1'b1;
          default: go_fault = 1'b1;
        endcase

        if (go_halt) begin
          next_state = S_HALT;
        end else if (go_fault) begin
          next_state = S_FAULT;
          next_fault = 2'b01;
        end else if (last_step) begin
          instr_done = 1'b1;
          next_state = run_en ? S_T0 : S_IDLE;
          next_step  = 3'd3;
        end else begin
          next_step = step + 3'd1;
        end
      end
      default: ;
    endcase

    // A memory step that is still waiting overrides the normal advance;
    // the MEM_TIMEOUT-th consecutive low cycle gives up with a fault.
    if (mem_step && !mem_ready) begin
      instr_done = 1'b0;
      next_step  = step;
      if (wait_cnt == LAST_WAIT) begin
        next_state = S_FAULT;
        next_fault = 2'b10;
      end else begin
        next_state = state;
      end
    end
  end

  assign reg_ctl     = {gra, grb, grc, rin, rout, ba_out, y_in};
  assign ld_ctl      = {mar_in, mdr_in, ir_in, pc_in, z_in, hi_in, lo_in, con_ff_in};
  assign bus_ctl     = {pc_out, mdr_out, zlow_out, zhigh_out, c_out, hi_out, lo_out};
  assign alu_control = alu;
  assign mem_ctl     = {mem_read, mem_write};
  assign busy        = (state == S_T0) || (state == S_T1) || (state == S_T2) || (state == S_EXEC);
  assign halted      = (state == S_HALT);
  assign fault       = fault_q;

endmodule

// File: tb/tb_control_unit_v2.sv
// tb_control_unit_v2 -- scoreboard bench for control_unit_v2.
// Stimulus drives one cycle at a time just after the rising edge and queues
// the hand-computed outputs for that cycle; the monitor compares on the
// falling edge.
module tb_control_unit_v2;

  typedef struct packed {
    logic [6:0] rc;
    logic [7:0] lc;
    logic [6:0] bc;
    logic [4:0] alu;
    logic [1:0] mem;
    logic       busy;
    logic       halted;
    logic       done;
    logic [1:0] fault;
  } exp_t;

  localparam logic [6:0] GRA = 7'h40, GRB = 7'h20, GRC = 7'h10, RIN = 7'h08,
                         ROUT = 7'h04, BAOUT = 7'h02, YIN = 7'h01;
  localparam logic [7:0] MARIN = 8'h80, MDRIN = 8'h40, IRIN = 8'h20, PCIN = 8'h10,
                         ZIN = 8'h08, HIIN = 8'h04, LOIN = 8'h02, CONIN = 8'h01;
  localparam logic [6:0] PCOUT = 7'h40, MDROUT = 7'h20, ZLOUT = 7'h10, ZHOUT = 7'h08,
                         COUT = 7'h04;
  localparam logic [1:0] MRD = 2'b10, MWR = 2'b01;

  logic        clk = 1'b0;
  logic        clr, run_en, mem_ready, con_ff;
  logic [31:0] IR, next_ir;
  logic [6:0]  reg_ctl, bus_ctl;
  logic [7:0]  ld_ctl;
  logic [4:0]  alu_control;
  logic [1:0]  mem_ctl, fault;
  logic        busy, halted, instr_done;

  int checks = 0;
  int errors = 0;
  exp_t  exp_q[$];
  string name_q[$];

  control_unit_v2 #(.IR_W(32), .OPC_W(5), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .clr(clr), .run_en(run_en), .IR(IR), .mem_ready(mem_ready),
    .con_ff(con_ff), .reg_ctl(reg_ctl), .ld_ctl(ld_ctl), .bus_ctl(bus_ctl),
    .alu_control(alu_control), .mem_ctl(mem_ctl), .busy(busy), .halted(halted),
    .instr_done(instr_done), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [6:0] rc, logic [7:0] lc, logic [6:0] bc, logic [4:0] alu,
                              logic [1:0] mem, logic bsy, logic hlt, logic dn, logic [1:0] flt);
    exp_t e;
    e = '{rc: rc, lc: lc, bc: bc, alu: alu, mem: mem, busy: bsy, halted: hlt, done: dn, fault: flt};
    return e;
  endfunction

  // Shorthand for a busy cycle with no halt or fault.
  function automatic exp_t ex(logic [6:0] rc, logic [7:0] lc, logic [6:0] bc, logic [4:0] alu,
                              logic [1:0] mem, logic dn);
    return mk(rc, lc, bc, alu, mem, 1'b1, 1'b0, dn, 2'b00);
  endfunction

  function automatic logic [31:0] ir_of(logic [4:0] opc);
    return {opc, 27'd0};
  endfunction

  task automatic checkOutput(input exp_t e, input string nm);
    exp_t a;
    a = '{rc: reg_ctl, lc: ld_ctl, bc: bus_ctl, alu: alu_control, mem: mem_ctl,
          busy: busy, halted: halted, done: instr_done, fault: fault};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s: got reg=%h ld=%h bus=%h alu=%0d mem=%b busy=%b halt=%b done=%b fault=%b, expected reg=%h ld=%h bus=%h alu=%0d mem=%b busy=%b halt=%b done=%b fault=%b",
               nm, a.rc, a.lc, a.bc, a.alu, a.mem, a.busy, a.halted, a.done, a.fault,
               e.rc, e.lc, e.bc, e.alu, e.mem, e.busy, e.halted, e.done, e.fault);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checkOutput(e, nm);
    end
  end

  task automatic applyStimulus(input logic re, input logic mr, input logic cf,
                               input exp_t e, input string nm);
    @(posedge clk);
    #1;
    run_en    = re;
    mem_ready = mr;
    con_ff    = cf;
    IR        = next_ir;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic doFetch(input logic re, input string nm);
    applyStimulus(re, 1'b1, 1'b0, ex(0, MARIN | ZIN, PCOUT, 5'd19, 0, 0), {nm, "_t0"});
    applyStimulus(re, 1'b1, 1'b0, ex(0, PCIN | MDRIN, ZLOUT, 0, MRD, 0), {nm, "_t1"});
    applyStimulus(re, 1'b1, 1'b0, ex(0, IRIN, MDROUT, 0, 0, 0), {nm, "_t2"});
  endtask

  task automatic startInstr(input logic [4:0] opc, input string nm);
    next_ir = ir_of(opc);
    applyStimulus(1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), {nm, "_idle"});
    doFetch(1'b0, nm);
  endtask

  task automatic idleCheck(input string nm);
    applyStimulus(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), nm);
  endtask

  // Asserts clr mid-cycle: the outputs must already read IDLE at the next falling edge.
  task automatic resetPulse(input string nm);
    @(posedge clk);
    #1;
    clr    = 1'b0;
    run_en = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    clr = 1'b1;
  endtask

  task automatic ldFront(input string nm);
    applyStimulus(0, 1, 0, ex(GRB | BAOUT | ROUT | YIN, 0, 0, 0, 0, 0), {nm, "_t3"});
    applyStimulus(0, 1, 0, ex(0, ZIN, COUT, 5'd3, 0, 0), {nm, "_t4"});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clr = 1'b0; run_en = 1'b0; mem_ready = 1'b1; con_ff = 1'b0;
    IR = '0; next_ir = '0;
    #2;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    name_q.push_back("reset_state");
    @(posedge clk);
    @(posedge clk);
    #1;
    clr = 1'b1;
    idleCheck("idle_after_reset");

    // add, run_en held: returns straight to T0, then a nop back to IDLE
    next_ir = 32'h1800_0000;
    applyStimulus(1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "add_idle");
    doFetch(1'b1, "add");
    applyStimulus(1, 1, 0, ex(GRB | ROUT | YIN, 0, 0, 0, 0, 0), "add_t3");
    applyStimulus(1, 1, 0, ex(GRC | ROUT, ZIN, 0, 5'd3, 0, 0), "add_t4");
    applyStimulus(1, 1, 0, ex(GRA | RIN, 0, ZLOUT, 0, 0, 1), "add_t5");
    next_ir = ir_of(5'd26);
    doFetch(1'b0, "nop");
    applyStimulus(0, 1, 0, ex(0, 0, 0, 0, 0, 1), "nop_t3");
    idleCheck("nop_idle");

    // ld with three wait cycles in T6
    startInstr(5'd0, "ld");
    ldFront("ld");
    applyStimulus(0, 1, 0, ex(0, MARIN, ZLOUT, 0, 0, 0), "ld_t5");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, (i == 3), 0, ex(0, MDRIN, 0, 0, MRD, 0), $sformatf("ld_t6_%0d", i));
    applyStimulus(0, 1, 0, ex(GRA | RIN, 0, MDROUT, 0, 0, 1), "ld_t7");
    idleCheck("ld_idle");

    // sub with run_en dropped in T4
    next_ir = ir_of(5'd4);
    applyStimulus(1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "sub_idle0");
    doFetch(1'b1, "sub");
    applyStimulus(1, 1, 0, ex(GRB | ROUT | YIN, 0, 0, 0, 0, 0), "sub_t3");
    applyStimulus(0, 1, 0, ex(GRC | ROUT, ZIN, 0, 5'd4, 0, 0), "sub_t4");
    applyStimulus(0, 1, 0, ex(GRA | RIN, 0, ZLOUT, 0, 0, 1), "sub_t5");
    idleCheck("sub_idle");

    // br with the condition false, then true
    for (int c = 0; c < 2; c++) begin
      startInstr(5'd19, $sformatf("br%0d", c));
      applyStimulus(0, 1, 0, ex(GRA | ROUT, CONIN, 0, 0, 0, 0), $sformatf("br%0d_t3", c));
      applyStimulus(0, 1, 0, ex(YIN, 0, PCOUT, 0, 0, 0), $sformatf("br%0d_t4", c));
      applyStimulus(0, 1, 0, ex(0, ZIN, COUT, 5'd3, 0, 0), $sformatf("br%0d_t5", c));
      applyStimulus(0, 1, c[0], ex(0, (c == 1) ? PCIN : 8'h00, ZLOUT, 0, 0, 1),
                    $sformatf("br%0d_t6", c));
    end
    idleCheck("br_idle");

    // st with one wait cycle in T7
    startInstr(5'd2, "st");
    ldFront("st");
    applyStimulus(0, 1, 0, ex(0, MARIN, ZLOUT, 0, 0, 0), "st_t5");
    applyStimulus(0, 1, 0, ex(GRA | ROUT, MDRIN, 0, 0, 0, 0), "st_t6");
    applyStimulus(0, 0, 0, ex(0, 0, 0, 0, MWR, 0), "st_t7_wait");
    applyStimulus(0, 1, 0, ex(0, 0, 0, 0, MWR, 1), "st_t7_done");
    idleCheck("st_idle");

    // mul
    startInstr(5'd16, "mul");
    applyStimulus(0, 1, 0, ex(GRA | ROUT | YIN, 0, 0, 0, 0, 0), "mul_t3");
    applyStimulus(0, 1, 0, ex(GRB | ROUT, ZIN, 0, 5'd16, 0, 0), "mul_t4");
    applyStimulus(0, 1, 0, ex(0, LOIN, ZLOUT, 0, 0, 0), "mul_t5");
    applyStimulus(0, 1, 0, ex(0, HIIN, ZHOUT, 0, 0, 1), "mul_t6");

    // andi
    startInstr(5'd13, "andi");
    applyStimulus(0, 1, 0, ex(GRB | ROUT | YIN, 0, 0, 0, 0, 0), "andi_t3");
    applyStimulus(0, 1, 0, ex(0, ZIN, COUT, 5'd5, 0, 0), "andi_t4");
    applyStimulus(0, 1, 0, ex(GRA | RIN, 0, ZLOUT, 0, 0, 1), "andi_t5");

    // neg
    startInstr(5'd17, "neg");
    applyStimulus(0, 1, 0, ex(GRB | ROUT, ZIN, 0, 5'd17, 0, 0), "neg_t3");
    applyStimulus(0, 1, 0, ex(GRA | RIN, 0, ZLOUT, 0, 0, 1), "neg_t4");

    // ldi
    startInstr(5'd1, "ldi");
    ldFront("ldi");
    applyStimulus(0, 1, 0, ex(GRA | RIN, 0, ZLOUT, 0, 0, 1), "ldi_t5");
    idleCheck("ldi_idle");

    // illegal opcode 31
    startInstr(5'd31, "ill");
    applyStimulus(1, 1, 0, ex(0, 0, 0, 0, 0, 0), "ill_t3");
    applyStimulus(1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01), "ill_fault_a");
    applyStimulus(1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01), "ill_fault_b");
    resetPulse("ill_clr");
    idleCheck("ill_idle");

    // mem_ready stuck low in T1 for 16 cycles
    next_ir = ir_of(5'd26);
    applyStimulus(1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "to_idle");
    applyStimulus(0, 1, 0, ex(0, MARIN | ZIN, PCOUT, 5'd19, 0, 0), "to_t0");
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 0, 0, ex(0, PCIN | MDRIN, ZLOUT, 0, MRD, 0), $sformatf("to_t1_%0d", i));
    applyStimulus(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10), "to_fault_a");
    applyStimulus(1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10), "to_fault_b");
    resetPulse("to_clr");

    // mem_ready arrives on the 16th cycle: no fault
    applyStimulus(1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "edge_idle");
    applyStimulus(0, 1, 0, ex(0, MARIN | ZIN, PCOUT, 5'd19, 0, 0), "edge_t0");
    for (int i = 0; i < 16; i++)
      applyStimulus(0, (i == 15), 0, ex(0, PCIN | MDRIN, ZLOUT, 0, MRD, 0), $sformatf("edge_t1_%0d", i));
    applyStimulus(0, 1, 0, ex(0, IRIN, MDROUT, 0, 0, 0), "edge_t2");
    applyStimulus(0, 1, 0, ex(0, 0, 0, 0, 0, 1), "edge_t3");
    idleCheck("edge_idle_end");

    // halt
    startInstr(5'd27, "halt");
    applyStimulus(1, 1, 0, ex(0, 0, 0, 0, 0, 0), "halt_t3");
    applyStimulus(1, 1, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "halt_a");
    applyStimulus(1, 1, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "halt_b");
    resetPulse("halt_clr");
    idleCheck("halt_idle");

    // clr asserted while ld waits in T6
    startInstr(5'd0, "ldclr");
    ldFront("ldclr");
    applyStimulus(0, 1, 0, ex(0, MARIN, ZLOUT, 0, 0, 0), "ldclr_t5");
    applyStimulus(0, 0, 0, ex(0, MDRIN, 0, 0, MRD, 0), "ldclr_t6");
    resetPulse("ldclr_clr");
    idleCheck("ldclr_idle");

    // clean restart after the reset
    startInstr(5'd17, "neg2");
    applyStimulus(0, 1, 0, ex(GRB | ROUT, ZIN, 0, 5'd17, 0, 0), "neg2_t3");
    applyStimulus(0, 1, 0, ex(GRA | RIN, 0, ZLOUT, 0, 0, 1), "neg2_t4");
    idleCheck("neg2_idle");

    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit_v2.md
CONTROL_UNIT_V2 -- requirements
Module: control_unit_v2

Interface
REQ-001 SHALL have parameter: IR_W, 32, instruction register width.
REQ-002 SHALL have parameter: OPC_W, 5, opcode width; opcode = IR[IR_W-1 -: OPC_W].
REQ-003 SHALL have parameter: MEM_TIMEOUT, 16, max consecutive mem_ready-low cycles tolerated per memory step (>=1).
REQ-004 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port: clr  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: run_en  in  1  permits instruction start.
REQ-007 SHALL have port: IR  in  IR_W  instruction register contents.
REQ-008 SHALL have port: mem_ready  in  1  memory completes current access this cycle.
REQ-009 SHALL have port: con_ff  in  1  branch-condition flip-flop result.
REQ-010 SHALL have port: reg_ctl  out  7  {Gra,Grb,Grc,Rin,Rout,BAout,y_in}.
REQ-011 SHALL have port: ld_ctl  out  8  {MARin,mdr_in,ir_in,pc_in,z_in,hi_in,lo_in,CON_FF_in}.
REQ-012 SHALL have port: bus_ctl  out  7  {pc_out,mdr_out,zlow_out,zhigh_out,c_out,hi_out,lo_out}.
REQ-013 SHALL have port: alu_control  out  5  ALU op code.
REQ-014 SHALL have port: mem_ctl  out  2  {memRead,memWrite}.
REQ-015 SHALL have port: busy, halted, instr_done  out  1 each; fault  out  2 (01 illegal opcode, 10 memory timeout).

Function
REQ-016 SHALL be fully synchronous apart from clr; no delay-based sequencing; each step lasts exactly one clock unless waiting on mem_ready.
REQ-017 SHALL implement states IDLE, T0, T1, T2, EXEC (step counter 3..7), HALT, FAULT; control outputs decoded combinationally from state, step, opcode; unlisted signals 0.
REQ-018 IDLE: all outputs 0; -> T0 when run_en=1.
REQ-019 T0: pc_out, MARin, z_in, alu_control=19 (PC+1).
REQ-020 T1: zlow_out, pc_in, memRead, mdr_in; hold while mem_ready=0; -> T2 on mem_ready=1.
REQ-021 T2: mdr_out, ir_in; -> EXEC step 3; opcode decoded from IR during step 3 onward.
REQ-022 add(3)/sub(4)/and(5)/or(6): T3 Grb,Rout,y_in; T4 Grc,Rout,z_in,alu=opcode; T5 zlow_out,Gra,Rin.
REQ-023 addi(12)/andi(13)/ori(14): T3 Grb,Rout,y_in; T4 c_out,z_in,alu=3/5/6; T5 zlow_out,Gra,Rin.
REQ-024 ld(0): T3 Grb,BAout,Rout,y_in; T4 c_out,z_in,alu=3; T5 zlow_out,MARin; T6 memRead,mdr_in (mem wait); T7 mdr_out,Gra,Rin.
REQ-025 ldi(1): T3,T4 as ld; T5 zlow_out,Gra,Rin.
REQ-026 st(2): T3-T5 as ld; T6 Gra,Rout,mdr_in; T7 memWrite (mem wait).
REQ-027 div(15)/mul(16): T3 Gra,Rout,y_in; T4 Grb,Rout,z_in,alu=opcode; T5 zlow_out,lo_in; T6 zhigh_out,hi_in.
REQ-028 neg(17)/not(18): T3 Grb,Rout,z_in,alu=opcode; T4 zlow_out,Gra,Rin.
REQ-029 br(19): T3 Gra,Rout,CON_FF_in; T4 pc_out,y_in; T5 c_out,z_in,alu=3; T6 zlow_out, pc_in=con_ff.
REQ-030 nop(26): T3 no controls, completes. halt(27): T3 -> HALT, halted=1. Any other opcode: T3 no controls -> FAULT, fault=01.
REQ-031 instr_done SHALL pulse 1 during final step of each completing instruction; next state T0 if run_en=1, else IDLE.
REQ-032 Memory wait: wait counter cleared on entering T1/ld T6/st T7; increments each mem_ready=0 cycle; MEM_TIMEOUT-th consecutive low cycle -> FAULT, fault=10.
REQ-033 mem_ready=1 on timeout cycle: access completes, no fault.
REQ-034 run_en deassert mid-instruction SHALL NOT abort; takes effect at completion.
REQ-035 HALT and FAULT: all control outputs 0; exited only by clr.
REQ-036 busy=1 in every state except IDLE, HALT, FAULT.

Reset
REQ-037 clr=0 SHALL immediately force IDLE, step=3, wait counter=0, fault=00, halted=0, all outputs 0, regardless of state or pending memory wait.

Verification
REQ-038 run_en=1, mem_ready=1, IR=0x18000000 (add) -> controls per REQ-019..022, instr_done in 6th cycle after IDLE exit, then T0.
REQ-039 ld with mem_ready low 3 cycles in T6 -> T6 held 4 cycles, instr_done at cycle 11, no fault.
REQ-040 br with con_ff=0 then con_ff=1 -> pc_in=0 in T6 first, pc_in=1 second.
REQ-041 IR opcode 31 -> FAULT, fault=01; mem_ready stuck 0 in T1 -> FAULT after 16 cycles, fault=10; mem_ready=1 on 16th -> no fault.
REQ-042 halt opcode -> halted=1, outputs 0; clr pulse low mid-ld T6 -> IDLE, all outputs 0 asynchronously.
REQ-043 run_en dropped in T4 of sub -> sub completes, instr_done, then IDLE, busy=0.
